// File: rtl/direct_sound_fifo.sv
// direct_sound_fifo: Direct Sound sample FIFO with DMA request FSM; DSOUND_HALFWORD_WRITE_EN enables halfword writes.
module direct_sound_fifo #(
    parameter int DEPTH_BYTES   = 32,
    parameter int REQ_THRESHOLD = 16,
    parameter int REQ_BYTES     = 16
) (
    input  logic                           clk,
    input  logic                           rst_b,
    input  logic                           wr_en,
    input  logic [31:0]                    wr_data,
    input  logic [1:0]                     wr_size,
    input  logic                           wr_addr_hi,
    input  logic                           fifo_clear,
    input  logic                           enable,
    input  logic                           timer_tick,
    output logic [7:0]                     sample,
    output logic                           sample_valid,
    output logic                           sound_req,
    output logic [$clog2(DEPTH_BYTES):0]   count,
    output logic                           overflow,
    output logic                           underflow
);
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = AW + 1;
    localparam int XW = CW + 1;
    typedef enum logic [1:0] {IDLE, REQ, COOL} state_t;
    state_t          state_q, state_d;
    logic [7:0]      mem_q [DEPTH_BYTES];
    logic [AW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XW-1:0]   acc_q, acc_d, need;
    logic [7:0]      sample_q, sample_d;
    logic            sample_valid_q, sample_valid_d;
    logic            sound_req_q, sound_req_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;
    logic [2:0]      n;
    logic [31:0]     wbytes;
    logic            pop, wr_ok, accept, drop;
`ifdef DSOUND_HALFWORD_WRITE_EN
    logic [15:0]     lane;
    assign lane   = wr_addr_hi ? wr_data[31:16] : wr_data[15:0];
    assign n      = wr_size == 2'b10 ? 3'd4 : wr_size == 2'b01 ? 3'd2 : 3'd0;
    assign wbytes = wr_size == 2'b10 ? wr_data : {16'h0, lane};
`else
    logic            unused_hi;
    assign unused_hi = wr_addr_hi;
    assign n         = wr_size == 2'b10 ? 3'd4 : 3'd0;
    assign wbytes    = wr_data;
`endif
    assign pop    = timer_tick && count_q != '0 && !fifo_clear;
    // Room check sees the slot freed by a same-cycle pop.
    assign need   = XW'(count_q) - XW'(pop) + XW'(n);
    assign wr_ok  = wr_en && n != 3'd0 && !fifo_clear;
    assign accept = wr_ok && need <= XW'(DEPTH_BYTES);
    assign drop   = wr_ok && !accept;
    always_comb begin
        rptr_d         = fifo_clear ? '0 : rptr_q + AW'(pop);
        wptr_d         = fifo_clear ? '0 : accept ? wptr_q + AW'(n) : wptr_q;
        count_d        = fifo_clear ? '0 : count_q + (accept ? CW'(n) : '0) - CW'(pop);
        overflow_d     = !fifo_clear && (overflow_q || drop);
        sample_d       = pop ? mem_q[rptr_q] : sample_q;
        sample_valid_d = pop;
        underflow_d    = timer_tick && count_q == '0 && !fifo_clear;
        state_d        = state_q;
        acc_d          = acc_q;
        case (state_q)
            IDLE: if (enable && count_q <= CW'(REQ_THRESHOLD)) begin
                state_d = REQ;
                acc_d   = '0;
            end
            REQ: begin
                acc_d   = accept ? acc_q + XW'(n) : acc_q;
                state_d = (!enable || (accept && acc_q + XW'(n) >= XW'(REQ_BYTES))) ? COOL : REQ;
            end
            default: state_d = IDLE;
        endcase
        if (fifo_clear) begin
            state_d = IDLE;
            acc_d   = '0;
        end
        sound_req_d = state_d == REQ;
    end
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q        <= IDLE;
            rptr_q         <= '0;
            wptr_q         <= '0;
            count_q        <= '0;
            acc_q          <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            sound_req_q    <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            rptr_q         <= rptr_d;
            wptr_q         <= wptr_d;
            count_q        <= count_d;
            acc_q          <= acc_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            sound_req_q    <= sound_req_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end
    always_ff @(posedge clk) begin
        if (accept && !rst_b)
            for (int i = 0; i < 4; i++)
                if (3'(i) < n) mem_q[wptr_q + AW'(i)] <= wbytes[8*i +: 8];
    end
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign sound_req    = sound_req_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
endmodule

// File: tb/tb_direct_sound_fifo.sv
// tb_direct_sound_fifo: directed self-checking bench for direct_sound_fifo (default build, halfword writes disabled).
module tb_direct_sound_fifo;
    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [1:0]  wr_size = 2'b10;
    logic        wr_addr_hi = 1'b0;
    logic        fifo_clear = 1'b0;
    logic        enable = 1'b0;
    logic        timer_tick = 1'b0;
    logic [7:0]  sample;
    logic        sample_valid, sound_req, overflow, underflow;
    logic [5:0]  count;
    int          n_chk = 0;
    int          n_pass = 0;

    direct_sound_fifo dut (
        .clk(clk), .rst_b(rst_b), .wr_en(wr_en), .wr_data(wr_data), .wr_size(wr_size),
        .wr_addr_hi(wr_addr_hi), .fifo_clear(fifo_clear), .enable(enable), .timer_tick(timer_tick),
        .sample(sample), .sample_valid(sample_valid), .sound_req(sound_req), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr_word(input logic [31:0] d);
        wr_en = 1'b1; wr_size = 2'b10; wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic tick();
        timer_tick = 1'b1;
        cyc();
        timer_tick = 1'b0;
    endtask

    initial begin
        cyc(); cyc();
        rst_b = 1'b0;
        check("rst_sample", sample, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_req", sound_req, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);

        wr_word(32'h03020100); wr_word(32'h07060504); wr_word(32'h0B0A0908); wr_word(32'h0F0E0D0C);
        check("fill16_count", count, 16);
        timer_tick = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            check("pop_sample", sample, i);
            check("pop_valid", sample_valid, 1);
        end
        timer_tick = 1'b0;
        cyc();
        check("pop_valid_idle", sample_valid, 0);
        check("pop_count0", count, 0);

        enable = 1'b1;
        cyc();
        check("req_rise", sound_req, 1);
        wr_en = 1'b1; wr_size = 2'b10;
        for (int i = 0; i < 4; i++) begin
            wr_data = 32'h13121110 + 32'h04040404 * i;
            cyc();
            if (i < 3) check("req_held", sound_req, 1);
        end
        wr_en = 1'b0;
        check("req_drop", sound_req, 0);
        check("req_count16", count, 16);
        cyc();
        check("req_cool_low", sound_req, 0);
        cyc();
        check("req_rerise", sound_req, 1);
        enable = 1'b0;
        cyc();
        check("req_disable", sound_req, 0);

        wr_word(32'h23222120); wr_word(32'h27262524); wr_word(32'h2B2A2928); wr_word(32'h2F2E2D2C);
        check("full_count", count, 32);
        check("full_ovf0", overflow, 0);
        wr_word(32'hDEADBEEF);
        check("drop_count", count, 32);
        check("drop_ovf", overflow, 1);
        tick();
        check("wrap_sample", sample, 8'h10);
        check("c31_count", count, 31);
        timer_tick = 1'b1;
        wr_word(32'h99999999);
        timer_tick = 1'b0;
        check("c31_pop_sample", sample, 8'h11);
        check("c31_count30", count, 30);

        fifo_clear = 1'b1;
        cyc();
        fifo_clear = 1'b0;
        check("clr_count", count, 0);
        check("clr_ovf", overflow, 0);
        check("clr_sample", sample, 8'h11);
        tick();
        check("unf_pulse", underflow, 1);
        check("unf_sample", sample, 8'h11);
        check("unf_valid", sample_valid, 0);
        cyc();
        check("unf_clear", underflow, 0);
        timer_tick = 1'b1;
        wr_word(32'h44332255);
        timer_tick = 1'b0;
        check("unf_wr_pulse", underflow, 1);
        check("unf_wr_count", count, 4);
        tick();
        check("unf_wr_sample", sample, 8'h55);
        check("unf_wr_count3", count, 3);

        wr_en = 1'b1; wr_size = 2'b01; wr_addr_hi = 1'b1; wr_data = 32'hAABB0000;
        cyc();
        wr_en = 1'b0; wr_size = 2'b10; wr_addr_hi = 1'b0;
        check("hw_count", count, 3);
        check("hw_ovf", overflow, 0);

        fifo_clear = 1'b1;
        cyc();
        fifo_clear = 1'b0;
        enable = 1'b1;
        cyc();
        wr_word(32'h0000_0001); wr_word(32'h0000_0002);
        check("mid_count8", count, 8);
        check("mid_req", sound_req, 1);
        rst_b = 1'b1; timer_tick = 1'b1;
        cyc();
        rst_b = 1'b0; timer_tick = 1'b0;
        check("mrst_sample", sample, 0);
        check("mrst_valid", sample_valid, 0);
        check("mrst_req", sound_req, 0);
        check("mrst_count", count, 0);
        check("mrst_ovf", overflow, 0);
        check("mrst_unf", underflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/direct_sound_fifo.md
# direct_sound_fifo

Receive-side endpoint of the sound-DMA path: a 32-byte Direct Sound sample FIFO that accepts DMA writes to FIFO_A or FIFO_B and asserts `sound_req` to DMA1 or DMA2 when it runs low. Each timer overflow tick pops one signed 8-bit PCM sample to the mixer. One instance per channel (A, B) sits between the memory-mapped I/O write decode and the sound mixer.

## Interface

Parameters:

- `DEPTH_BYTES`, default 32: FIFO capacity in bytes, a power of two.
- `REQ_THRESHOLD`, default 16: `sound_req` is raised when occupancy is ≤ this many bytes.
- `REQ_BYTES`, default 16: bytes accepted after a request before `sound_req` drops (4 words).

Ports:

- `clk` input, 1 bit: system clock.
- `rst_b` input, 1 bit: synchronous reset. It is active-high despite the codebase name and is sampled on the `clk` rising edge.
- `wr_en` input, 1 bit: one-cycle write strobe from the FIFO_x register decode.
- `wr_data` input, 32 bits: write data. Halfword data is on [15:0] or [31:16] according to `wr_addr_hi`.
- `wr_size` input, 2 bits: 2'b10 word, 2'b01 halfword. Other codes are ignored.
- `wr_addr_hi` input, 1 bit: address bit 1 for halfword writes.
- `fifo_clear` input, 1 bit: SOUNDCNT_H FIFO-reset bit, one-cycle pulse.
- `enable` input, 1 bit: channel routed to L or R. When low, `sound_req` is forced low.
- `timer_tick` input, 1 bit: selected timer overflow pulse, which pops one byte.
- `sample` output, 8 bits: current signed PCM sample.
- `sample_valid` output, 1 bit: one-cycle pulse when `sample` updates.
- `sound_req` output, 1 bit: level request to the paired DMA unit.
- `count` output, $clog2(DEPTH_BYTES)+1 bits: occupancy in bytes.
- `overflow` output, 1 bit: sticky flag, set on a dropped write.
- `underflow` output, 1 bit: one-cycle pulse on a tick while empty.

## Operation

- Storage is a byte-wide circular buffer with read pointer, write pointer and byte count. Pointers wrap modulo `DEPTH_BYTES`.
- Word write: pushes 4 bytes in the order [7:0], [15:8], [23:16], [31:24].
- Halfword write: pushes 2 bytes, low byte first, from [15:0] (`wr_addr_hi`=0) or [31:16] (`wr_addr_hi`=1).
- Writes are all-or-nothing. If `count + n > DEPTH_BYTES`, the whole write is dropped and `overflow` is set. `overflow` clears only on reset or `fifo_clear`.
- Pop: on `timer_tick` with `count > 0`, the oldest byte loads into `sample`. Otherwise `sample` holds and `underflow` pulses.
- Same-cycle push and pop: the pop takes the oldest pre-write byte. Then `count <= count + n - 1`, and the full check uses `count - pop`. There is no bypass: a tick on an empty FIFO with a simultaneous write still underflows, and the write is accepted.
- `fifo_clear` has priority over writes and ticks in the same cycle. It zeroes the pointers, `count`, `overflow` and the request state. `sample` holds.
- Request FSM, states IDLE, REQ, COOL:
  - IDLE → REQ when `enable` and `count ≤ REQ_THRESHOLD`. Entering REQ clears the `acc` byte counter.
  - In REQ, `sound_req`=1 and `acc` adds bytes from accepted writes.
  - REQ → COOL when `acc + n ≥ REQ_BYTES`, or when `enable` falls.
  - COOL → IDLE unconditionally. This guarantees at least one low cycle so a repeating DMA does not retrigger on a stale level.
  - `fifo_clear` or reset forces IDLE.

## Timing

- All outputs are registered.
- Reset values:
  - `sample`=0, `sample_valid`=0, `sound_req`=0
  - `count`=0, `overflow`=0, `underflow`=0
  - pointers 0, FSM IDLE
- Write on cycle N: `count` reflects it at N+1. A pop of those bytes is possible from N+1.
- Tick on cycle N: `sample` and `sample_valid` update at N+1. `underflow` also pulses at N+1.
- `sound_req` rises 1 cycle after the threshold condition is registered (at most 2 cycles after the causing pop). It falls the cycle after the completing write and is low for at least 1 cycle.

## Configuration

- `DSOUND_HALFWORD_WRITE_EN` defined: halfword writes are accepted as described.
- Not defined: only `wr_size`=2'b10 writes are accepted. Halfword writes are dropped without setting `overflow`, and the halfword lane-select logic is not compiled.

## Test plan

- Reset, then 4 word writes 0x03020100..0x0F0E0D0C → `count`=16. 16 ticks → `sample` 0x00..0x0F in order, one `sample_valid` each, `count`=0.
- Empty FIFO with `enable`=1 → `sound_req`=1 within 2 cycles. 4 word writes → `sound_req`=0 the cycle after the 4th write, low ≥1 cycle, then re-raised because `count`=16 ≤ 16.
- Fill to 32 bytes, then write a word → dropped, `count`=32, `overflow`=1. Then `fifo_clear` → `count`=0, `overflow`=0, `sample` unchanged.
- Tick on empty → `underflow` pulses, `sample` holds its last value. Count at 31 with a same-cycle word write and tick → write dropped, pop occurs, `count`=30.
- With `DSOUND_HALFWORD_WRITE_EN`: halfword 0xAABB0000 with `wr_addr_hi`=1 → pushes 0xBB then 0xAA. Without the macro → `count` unchanged, `overflow`=0.
- Assert `rst_b` mid-request with `count`=8 → next cycle all outputs at reset values and FSM IDLE.
